// File: rtl/am_burst_sequencer.sv
// am_burst_sequencer
// Drives the AM carrier DAC with timed bursts: latches a burst configuration
// on start, then cycles ON/OFF (with optional linear envelope ramps) for a
// programmed number of bursts, or forever when the burst count is 0.
// Optional feature macro: AM_BURST_RAMP_EN (adds RAMP_UP/RAMP_DOWN states).
//
// Handshake: there is no valid/ready pair here; start is a level sampled only
// in IDLE on enabled cycles, and done is a one-clock pulse on entry to IDLE.
// The FSM state is kept in the named signal `state` for checker binding.
module am_burst_sequencer #(
    parameter int WIDTH         = 13,
    parameter int LOG2_MAX_DIST = 11,
    parameter int PHASE_WIDTH   = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int BURST_WIDTH   = 8,
    parameter int RAMP_STEP     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       cfg_amplitude,
    input  logic [PHASE_WIDTH-1:0] cfg_freq_step,
    input  logic [CNT_WIDTH-1:0]   cfg_on_cycles,
    input  logic [CNT_WIDTH-1:0]   cfg_off_cycles,
    input  logic [BURST_WIDTH-1:0] cfg_bursts,
    output logic                   dac_enable,
    output logic [WIDTH-1:0]       dac_distance,
    output logic [PHASE_WIDTH-1:0] dac_freq_step,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] burst_count
);

    localparam logic [WIDTH-1:0] AMP_MAX = WIDTH'((2 ** LOG2_MAX_DIST) - 1);

`ifdef AM_BURST_RAMP_EN
    typedef enum logic [2:0] {IDLE, RAMP_UP, ON, RAMP_DOWN, OFF} state_t;
    localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(RAMP_STEP);
`else
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
`endif

    state_t                 state, state_d;
    logic [WIDTH-1:0]       amp, amp_d;
    logic [WIDTH-1:0]       tgt, tgt_d;
    logic [PHASE_WIDTH-1:0] freq, freq_d;
    logic [CNT_WIDTH-1:0]   on_len, on_len_d;
    logic [CNT_WIDTH-1:0]   off_len, off_len_d;
    logic [CNT_WIDTH-1:0]   on_cnt, on_cnt_d;
    logic [CNT_WIDTH-1:0]   off_cnt, off_cnt_d;
    logic [BURST_WIDTH-1:0] bursts_cfg, bursts_d;
    logic [BURST_WIDTH-1:0] count, count_d, count_inc;
    logic                   done_d;
    logic                   burst_end;
    logic                   last_burst;
    logic [WIDTH-1:0]       cfg_amp_clamped;
    logic [CNT_WIDTH-1:0]   cfg_on_len;
    logic                   dac_enable_q, busy_q, done_q;

`ifdef AM_BURST_RAMP_EN
    logic                   aborting, aborting_d;
    logic [WIDTH:0]         amp_up_sum;
    logic [WIDTH-1:0]       amp_up, amp_dn;

    // Envelope step values: saturate at the target going up and at 0 going down.
    assign amp_up_sum = {1'b0, amp} + STEP;
    assign amp_up     = (amp_up_sum >= {1'b0, tgt}) ? tgt : amp_up_sum[WIDTH-1:0];
    assign amp_dn     = ({1'b0, amp} > STEP) ? (amp - STEP[WIDTH-1:0]) : '0;
`endif

    // Configuration decode: clamp amplitude to DAC full scale, ON length at least 1.
    assign cfg_amp_clamped = (cfg_amplitude > AMP_MAX) ? AMP_MAX : cfg_amplitude;
    assign cfg_on_len      = (cfg_on_cycles == '0) ? CNT_WIDTH'(1) : cfg_on_cycles;
    assign count_inc       = count + BURST_WIDTH'(1);
    assign last_burst      = (bursts_cfg != '0) && (count_inc == bursts_cfg);

    // Next-state and datapath update; nothing advances unless enable is high.
    always_comb begin
        state_d   = state;
        amp_d     = amp;
        tgt_d     = tgt;
        freq_d    = freq;
        on_len_d  = on_len;
        off_len_d = off_len;
        on_cnt_d  = on_cnt;
        off_cnt_d = off_cnt;
        bursts_d  = bursts_cfg;
        count_d   = count;
        done_d    = 1'b0;
        burst_end = 1'b0;
`ifdef AM_BURST_RAMP_EN
        aborting_d = aborting;
`endif
        if (enable) begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tgt_d     = cfg_amp_clamped;
                        freq_d    = cfg_freq_step;
                        on_len_d  = cfg_on_len;
                        off_len_d = cfg_off_cycles;
                        bursts_d  = cfg_bursts;
                        count_d   = '0;
`ifdef AM_BURST_RAMP_EN
                        amp_d      = '0;
                        aborting_d = 1'b0;
                        state_d    = RAMP_UP;
`else
                        amp_d    = cfg_amp_clamped;
                        on_cnt_d = cfg_on_len;
                        state_d  = ON;
`endif
                    end
                end
`ifdef AM_BURST_RAMP_EN
                RAMP_UP: begin
                    if (abort) begin
                        aborting_d = 1'b1;
                        state_d    = RAMP_DOWN;
                    end else begin
                        amp_d = amp_up;
                        if (amp_up == tgt) begin
                            on_cnt_d = on_len;
                            state_d  = ON;
                        end
                    end
                end
`endif
                ON: begin
                    if (abort) begin
`ifdef AM_BURST_RAMP_EN
                        aborting_d = 1'b1;
                        state_d    = RAMP_DOWN;
`else
                        amp_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else if (on_cnt <= CNT_WIDTH'(1)) begin
`ifdef AM_BURST_RAMP_EN
                        state_d = RAMP_DOWN;
`else
                        amp_d     = '0;
                        burst_end = 1'b1;
`endif
                    end else begin
                        on_cnt_d = on_cnt - CNT_WIDTH'(1);
                    end
                end
`ifdef AM_BURST_RAMP_EN
                RAMP_DOWN: begin
                    // An abort seen while already ramping down also ends the sequence.
                    aborting_d = aborting | abort;
                    amp_d      = amp_dn;
                    if (amp_dn == '0) begin
                        if (aborting || abort) begin
                            aborting_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            burst_end = 1'b1;
                        end
                    end
                end
`endif
                OFF: begin
                    if (abort) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (off_cnt <= CNT_WIDTH'(1)) begin
`ifdef AM_BURST_RAMP_EN
                        state_d = RAMP_UP;
`else
                        amp_d    = tgt;
                        on_cnt_d = on_len;
                        state_d  = ON;
`endif
                    end else begin
                        off_cnt_d = off_cnt - CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            // Burst completion: count it, then finish, gap, or restart.
            if (burst_end) begin
                count_d = count_inc;
                if (last_burst) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
`ifdef AM_BURST_RAMP_EN
                    if (off_len == '0) begin
                        state_d = RAMP_UP;
                    end else begin
                        off_cnt_d = off_len;
                        state_d   = OFF;
                    end
`else
                    // Without ramps a zero-length gap still shows one zero-amplitude cycle.
                    off_cnt_d = off_len;
                    state_d   = OFF;
`endif
                end
            end
        end
    end

    // State, configuration and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            amp          <= '0;
            tgt          <= '0;
            freq         <= '0;
            on_len       <= '0;
            off_len      <= '0;
            on_cnt       <= '0;
            off_cnt      <= '0;
            bursts_cfg   <= '0;
            count        <= '0;
            dac_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef AM_BURST_RAMP_EN
            aborting     <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            amp          <= amp_d;
            tgt          <= tgt_d;
            freq         <= freq_d;
            on_len       <= on_len_d;
            off_len      <= off_len_d;
            on_cnt       <= on_cnt_d;
            off_cnt      <= off_cnt_d;
            bursts_cfg   <= bursts_d;
            count        <= count_d;
            dac_enable_q <= (state_d != IDLE) && (state_d != OFF);
            busy_q       <= (state_d != IDLE);
            done_q       <= done_d;
`ifdef AM_BURST_RAMP_EN
            aborting     <= aborting_d;
`endif
        end
    end

    assign dac_enable    = dac_enable_q;
    assign dac_distance  = amp;
    assign dac_freq_step = freq;
    assign busy          = busy_q;
    assign done          = done_q;
    assign burst_count   = count;

endmodule

// File: tb/tb_am_burst_sequencer.sv
// tb_am_burst_sequencer
// Directed, table-driven bench for am_burst_sequencer. The default build
// exercises the direct (no-ramp) sequencer; with AM_BURST_RAMP_EN defined the
// envelope-ramp scenario is checked instead. Common checks: reset values,
// ignored start, asynchronous reset mid-burst.
module tb_am_burst_sequencer;

    localparam int WIDTH       = 13;
    localparam int PHASE_WIDTH = 32;
    localparam int CNT_WIDTH   = 16;
    localparam int BURST_WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                   enable;
    logic                   start;
    logic                   abort;
    logic [WIDTH-1:0]       cfg_amplitude;
    logic [PHASE_WIDTH-1:0] cfg_freq_step;
    logic [CNT_WIDTH-1:0]   cfg_on_cycles;
    logic [CNT_WIDTH-1:0]   cfg_off_cycles;
    logic [BURST_WIDTH-1:0] cfg_bursts;
    logic                   dac_enable;
    logic [WIDTH-1:0]       dac_distance;
    logic [PHASE_WIDTH-1:0] dac_freq_step;
    logic                   busy;
    logic                   done;
    logic [BURST_WIDTH-1:0] burst_count;

    am_burst_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .start          (start),
        .abort          (abort),
        .cfg_amplitude  (cfg_amplitude),
        .cfg_freq_step  (cfg_freq_step),
        .cfg_on_cycles  (cfg_on_cycles),
        .cfg_off_cycles (cfg_off_cycles),
        .cfg_bursts     (cfg_bursts),
        .dac_enable     (dac_enable),
        .dac_distance   (dac_distance),
        .dac_freq_step  (dac_freq_step),
        .busy           (busy),
        .done           (done),
        .burst_count    (burst_count)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic xe, input logic [WIDTH-1:0] xd,
                              input logic xb, input logic xdn, input logic [BURST_WIDTH-1:0] xc);
        check({tag, ".dac_enable"},   64'(dac_enable),   64'(xe));
        check({tag, ".dac_distance"}, 64'(dac_distance), 64'(xd));
        check({tag, ".busy"},         64'(busy),         64'(xb));
        check({tag, ".done"},         64'(done),         64'(xdn));
        check({tag, ".burst_count"},  64'(burst_count),  64'(xc));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [WIDTH-1:0] amp, input logic [PHASE_WIDTH-1:0] fs,
                           input logic [CNT_WIDTH-1:0] on_c, input logic [CNT_WIDTH-1:0] off_c,
                           input logic [BURST_WIDTH-1:0] b);
        cfg_amplitude  = amp;
        cfg_freq_step  = fs;
        cfg_on_cycles  = on_c;
        cfg_off_cycles = off_c;
        cfg_bursts     = b;
    endtask

    task automatic pulse_start();
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                   st;
        logic                   ab;
        logic                   x_en;
        logic [WIDTH-1:0]       x_dist;
        logic                   x_busy;
        logic                   x_done;
        logic [BURST_WIDTH-1:0] x_cnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mkv(input logic st, input logic ab, input logic xe,
                                 input logic [WIDTH-1:0] xd, input logic xb, input logic xdn,
                                 input logic [BURST_WIDTH-1:0] xc);
        vec_t v;
        v.st = st; v.ab = ab; v.x_en = xe; v.x_dist = xd;
        v.x_busy = xb; v.x_done = xdn; v.x_cnt = xc;
        return v;
    endfunction

`ifdef AM_BURST_RAMP_EN
    // Expected envelope for amp=1000, on=10, off=5: 141-cycle burst period.
    function automatic logic [WIDTH-1:0] ramp_dist(input int p);
        int k;
        if (p == 0) return '0;
        if (p <= 63) return (16 * p > 1000) ? WIDTH'(1000) : WIDTH'(16 * p);
        if (p <= 73) return WIDTH'(1000);
        if (p <= 136) begin
            k = p - 73;
            return (1000 > 16 * k) ? WIDTH'(1000 - 16 * k) : '0;
        end
        return '0;
    endfunction
`endif

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        set_cfg('0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, '0, 1'b0, 1'b0, '0);
        check("reset.dac_freq_step", 64'(dac_freq_step), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // start is ignored while enable is low or abort is high
        set_cfg(13'd300, 32'h0000_1111, 16'd3, 16'd2, 8'd1);
        enable = 1'b0;
        start  = 1'b1;
        repeat (2) tick();
        check("start_no_enable.busy", 64'(busy), 64'd0);
        enable = 1'b1;
        abort  = 1'b1;
        tick();
        check("start_with_abort.busy", 64'(busy), 64'd0);
        check("start_with_abort.freq", 64'(dac_freq_step), 64'd0);
        start  = 1'b0;
        abort  = 1'b0;
        tick();

`ifdef AM_BURST_RAMP_EN
        // two ramped bursts, amplitude 1000, on 10, off 5
        set_cfg(13'd1000, 32'h0BAD_F00D, 16'd10, 16'd5, 8'd2);
        pulse_start();
        for (int c = 0; c <= 276; c++) begin
            int p;
            p = (c < 141) ? c : c - 141;
            exp_q.push_back(ramp_dist(p));
            check($sformatf("ramp_c%0d.dist", c), 64'(dac_distance), 64'(exp_q.pop_front()));
            check($sformatf("ramp_c%0d.en", c), 64'(dac_enable), 64'((p <= 135) ? 1 : 0));
            check($sformatf("ramp_c%0d.done", c), 64'(done), 64'd0);
            tick();
        end
        check_outs("ramp_end", 1'b0, '0, 1'b0, 1'b1, 8'd2);
        check("ramp_end.freq", 64'(dac_freq_step), 64'h0BAD_F00D);
        tick();
        check("ramp_end_next.done", 64'(done), 64'd0);

        // clamp: the envelope must top out at 2047
        begin
            logic [WIDTH-1:0] peak;
            int n;
            peak = '0;
            n = 0;
            set_cfg(13'd5000, 32'h1, 16'd1, 16'd0, 8'd1);
            pulse_start();
            while (busy && n < 400) begin
                if (dac_distance > peak) peak = dac_distance;
                tick();
                n++;
            end
            check("ramp_clamp.timeout", 64'(n < 400), 64'd1);
            check("ramp_clamp.peak", 64'(peak), 64'd2047);
        end
`else
        // table: amp 500, on 4, off 0, bursts 3; start while busy at row 2
        set_cfg(13'd500, 32'hA5A5_0001, 16'd4, 16'd0, 8'd3);
        tbl[0]  = mkv(1'b1, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd0);
        tbl[1]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd0);
        tbl[2]  = mkv(1'b1, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd0);
        tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd0);
        tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 13'd0,   1'b1, 1'b0, 8'd1);
        tbl[5]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd1);
        tbl[6]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd1);
        tbl[7]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd1);
        tbl[8]  = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd1);
        tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 13'd0,   1'b1, 1'b0, 8'd2);
        tbl[10] = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd2);
        tbl[11] = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd2);
        tbl[12] = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd2);
        tbl[13] = mkv(1'b0, 1'b0, 1'b1, 13'd500, 1'b1, 1'b0, 8'd2);
        tbl[14] = mkv(1'b0, 1'b0, 1'b0, 13'd0,   1'b0, 1'b1, 8'd3);
        tbl[15] = mkv(1'b0, 1'b0, 1'b0, 13'd0,   1'b0, 1'b0, 8'd3);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st;
            abort = tbl[i].ab;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].x_en, tbl[i].x_dist,
                       tbl[i].x_busy, tbl[i].x_done, tbl[i].x_cnt);
        end
        start = 1'b0;
        check("tbl_end.freq_held", 64'(dac_freq_step), 64'hA5A5_0001);

        // clamp: 5000 -> 2047, single burst of 2 cycles
        set_cfg(13'd5000, 32'h2, 16'd2, 16'd3, 8'd1);
        pulse_start();
        check_outs("clamp0", 1'b1, 13'd2047, 1'b1, 1'b0, 8'd0);
        tick();
        check_outs("clamp1", 1'b1, 13'd2047, 1'b1, 1'b0, 8'd0);
        tick();
        check_outs("clamp_end", 1'b0, 13'd0, 1'b0, 1'b1, 8'd1);

        // enable toggling: on=10 takes 20 clocks at half rate
        set_cfg(13'd100, 32'h3, 16'd10, 16'd2, 8'd1);
        pulse_start();
        for (int j = 1; j < 20; j++) exp_q.push_back(13'd100);
        for (int j = 1; j <= 20; j++) begin
            enable = (j % 2 == 0);
            tick();
            if (j < 20) begin
                check_outs($sformatf("toggle%0d", j), 1'b1, exp_q.pop_front(), 1'b1, 1'b0, 8'd0);
            end else begin
                check_outs("toggle_end", 1'b0, 13'd0, 1'b0, 1'b1, 8'd1);
            end
        end
        enable = 1'b0;
        tick();
        check("toggle_done_one_clk", 64'(done), 64'd0);
        enable = 1'b1;

        // continuous mode, cfg changes while busy ignored, count wraps, abort in ON
        set_cfg(13'd7, 32'h1234_5678, 16'd1, 16'd0, 8'd0);
        pulse_start();
        check_outs("cont_start", 1'b1, 13'd7, 1'b1, 1'b0, 8'd0);
        set_cfg(13'd99, 32'h0, 16'd9, 16'd9, 8'd1);
        repeat (6) tick();
        check_outs("cont_3", 1'b1, 13'd7, 1'b1, 1'b0, 8'd3);
        check("cont_3.freq", 64'(dac_freq_step), 64'h1234_5678);
        repeat (506) tick();
        check_outs("cont_wrap", 1'b1, 13'd7, 1'b1, 1'b0, 8'd0);
        abort = 1'b1;
        tick();
        check_outs("cont_abort_on", 1'b0, 13'd0, 1'b0, 1'b1, 8'd0);
        check("cont_abort_on.freq", 64'(dac_freq_step), 64'h1234_5678);
        abort = 1'b0;
        tick();
        check("cont_abort_after.done", 64'(done), 64'd0);
        abort = 1'b1;
        tick();
        check_outs("abort_idle", 1'b0, 13'd0, 1'b0, 1'b0, 8'd0);
        abort = 1'b0;

        // abort during OFF ends at once
        set_cfg(13'd300, 32'h4, 16'd1, 16'd5, 8'd0);
        pulse_start();
        check_outs("aoff0", 1'b1, 13'd300, 1'b1, 1'b0, 8'd0);
        tick();
        check_outs("aoff1", 1'b0, 13'd0, 1'b1, 1'b0, 8'd1);
        tick();
        check_outs("aoff2", 1'b0, 13'd0, 1'b1, 1'b0, 8'd1);
        abort = 1'b1;
        tick();
        check_outs("aoff_end", 1'b0, 13'd0, 1'b0, 1'b1, 8'd1);
        abort = 1'b0;
`endif

        // asynchronous reset in the middle of a burst
        set_cfg(13'd200, 32'hCAFE_0001, 16'd50, 16'd2, 8'd0);
        pulse_start();
        tick();
        check("pre_reset.busy", 64'(busy), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 13'd0, 1'b0, 1'b0, 8'd0);
        check("async_reset.freq", 64'(dac_freq_step), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_reset.busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
